// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-channel SRAM-like request arbiter with an in-order ID FIFO.
// Requests from NUM_CH masters are merged onto one SRAM-like bus.
// Each accepted request's channel ID is queued, and each mem_data_ok is routed
// back to the channel at the head of that queue.
// Optional feature: define ARB_RR_EN for round-robin arbitration. The default
// (undefined) is fixed priority, where the lowest channel index wins.
// Request and response paths are combinational (zero-cycle); only the
// arbiter state, lock channel, FIFO and round-robin pointer are registered.

module mem_req_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_wr,
    input  logic [2*NUM_CH-1:0]                ch_size,
    input  logic [ADDR_W*NUM_CH-1:0]           ch_addr,
    input  logic [DATA_W/8*NUM_CH-1:0]         ch_wstrb,
    input  logic [DATA_W*NUM_CH-1:0]           ch_wdata,
    output logic [NUM_CH-1:0]                  ch_addr_ok,
    output logic [NUM_CH-1:0]                  ch_data_ok,
    output logic [DATA_W-1:0]                  ch_rdata,
    output logic                               mem_req,
    output logic                               mem_wr,
    output logic [1:0]                         mem_size,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W/8-1:0]                mem_wstrb,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic                               mem_addr_ok,
    input  logic                               mem_data_ok,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Arbiter state: LOCKED keeps a stalled request's fields stable to the slave.
    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;

    // In-order ID FIFO.
    logic [CH_W-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Combinational control.
    logic              arb_found_s;
    logic [CH_W-1:0]   arb_ch_s;
    logic              req_pending_s;
    logic [CH_W-1:0]   grant_s;
    logic              full_s;
    logic              handshake_s;
    logic              pop_s;
    logic [CH_W-1:0]   head_id_s;

`ifdef ARB_RR_EN
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W:0]     rr_idx_s;

    // Round-robin winner: first requester found starting at rr_ptr, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_ch_s    = '0;
        rr_idx_s    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rr_idx_s = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            rr_idx_s = (rr_idx_s >= (CH_W+1)'(NUM_CH)) ? (rr_idx_s - (CH_W+1)'(NUM_CH)) : rr_idx_s;
            arb_ch_s    = (!arb_found_s && ch_req[rr_idx_s[CH_W-1:0]]) ? rr_idx_s[CH_W-1:0] : arb_ch_s;
            arb_found_s = arb_found_s | ch_req[rr_idx_s[CH_W-1:0]];
        end
    end

    // Next round-robin pointer: the channel after the one just accepted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake_s) begin
            rr_ptr_d = (grant_s == CH_W'(NUM_CH-1)) ? '0 : (grant_s + CH_W'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed-priority winner: scan high to low so the lowest requesting index wins.
    always_comb begin
        arb_found_s = 1'b0;
        arb_ch_s    = '0;
        for (int k = NUM_CH-1; k >= 0; k--) begin
            arb_ch_s    = ch_req[k] ? CH_W'(k) : arb_ch_s;
            arb_found_s = arb_found_s | ch_req[k];
        end
    end
`endif

    // Grant selection and bus handshake qualification.
    always_comb begin
        full_s    = (count_q == CNT_W'(MAX_OUTSTANDING));
        head_id_s = fifo_q[rd_ptr_q];
        if (state_q == ST_LOCKED) begin
            grant_s       = lock_ch_q;
            req_pending_s = 1'b1;
        end else begin
            grant_s       = arb_ch_s;
            req_pending_s = arb_found_s;
        end
        // Full is judged on the registered count, so a same-cycle pop does not unblock issue.
        mem_req     = req_pending_s & ~full_s & ~reset;
        handshake_s = mem_req & mem_addr_ok;
        // A response with nothing outstanding is a stray and is dropped.
        pop_s       = mem_data_ok & (count_q != '0) & ~reset;
    end

    // Request fields muxed from the granted channel; per-channel strobes.
    always_comb begin
        mem_wr     = ch_wr[grant_s];
        mem_size   = ch_size[int'(grant_s)*2 +: 2];
        mem_addr   = ch_addr[int'(grant_s)*ADDR_W +: ADDR_W];
        mem_wstrb  = ch_wstrb[int'(grant_s)*STRB_W +: STRB_W];
        mem_wdata  = ch_wdata[int'(grant_s)*DATA_W +: DATA_W];
        ch_addr_ok = '0;
        ch_addr_ok[grant_s] = handshake_s;
        ch_data_ok = '0;
        ch_data_ok[head_id_s] = pop_s;
        ch_rdata   = mem_rdata;
        outstanding = count_q;
    end

    // Arbiter next state: lock on a stalled request, release on handshake.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            ST_FREE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = grant_s;
                end else begin
                    state_d   = ST_FREE;
                end
            end
            ST_LOCKED: begin
                if (handshake_s) begin
                    state_d = ST_FREE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d   = ST_FREE;
                lock_ch_d = '0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FREE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // FIFO pointer and occupancy next state; push and pop together keep the count.
    always_comb begin
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        wr_ptr_d = handshake_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        case ({handshake_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and count; reset discards every outstanding ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (handshake_s) begin
                fifo_q[wr_ptr_q] <= grant_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a directed vector table for the documented
// scenarios, then randomized traffic against a queue-based reference model.
// Works with and without ARB_RR_EN.

module tb_mem_req_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 4;
`ifdef ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [N-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [2*N-1:0]  ch_size;
    logic [AW*N-1:0] ch_addr;
    logic [SW*N-1:0] ch_wstrb;
    logic [DW*N-1:0] ch_wdata;
    logic [DW-1:0]   ch_rdata, mem_rdata, mem_wdata;
    logic            mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]      mem_size;
    logic [AW-1:0]   mem_addr;
    logic [SW-1:0]   mem_wstrb;
    logic [2:0]      outstanding;

    mem_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wstrb(ch_wstrb), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit [1:0]  req;
        bit        aok;
        bit        dok;
        bit [31:0] rdata;
        bit        emreq;
        bit [1:0]  eaok;
        bit [1:0]  edok;
        int        eout;
        int        ech;
    } vec_t;

    vec_t tbl[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   bad        = 1'b0;

    logic [31:0] tbl_addr [N];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
            bad = 1'b1;
        end
    endtask

    task automatic close_vec();
        vectors++;
        if (bad) miscompares++;
        bad = 1'b0;
    endtask

    task automatic add(input bit rst, input bit [1:0] req, input bit aok, input bit dok,
                       input bit [31:0] rdata, input bit emreq, input bit [1:0] eaok,
                       input bit [1:0] edok, input int eout, input int ech);
        vec_t v;
        v.rst = rst; v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.emreq = emreq; v.eaok = eaok; v.edok = edok; v.eout = eout; v.ech = ech;
        tbl.push_back(v);
    endtask

    // Reference-model state (random phase)
    int          q[$];
    int          lock_ch;
    int          rr;
    bit          pend  [N];
    logic [31:0] raddr [N];
    logic        rwr   [N];
    logic [1:0]  rsize [N];
    logic [3:0]  rstrb [N];
    logic [31:0] rwdat [N];

    initial begin
        int ch;
        int g, start, c;
        bit any, mreq, hs, pop, full;

        tbl_addr[0] = 32'h1C00_0000;
        tbl_addr[1] = 32'h1C00_0100;

        // ---------------- vector table ----------------
        // T1: reset with both requesting
        add(1'b1, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        add(1'b1, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // T2: single issue then zero-latency response
        add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 0, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'h0240_0000, 1'b0, 2'b00, 2'b01, 1, 0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        add(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // T3: both requesting for 4 handshakes, then drain in issue order
        for (int k = 0; k < 4; k++) begin
            ch = RR_MODE ? (k % 2) : 0;
            add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01 << ch, 2'b00, k, ch);
        end
        for (int k = 0; k < 4; k++) begin
            ch = RR_MODE ? (k % 2) : 0;
            add(1'b0, 2'b00, 1'b0, 1'b1, 32'hA0 + k, 1'b0, 2'b00, 2'b01 << ch, 4 - k, 0);
        end
        add(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // T4: ch0 stalled, ch1 joins, address must stay ch0's
        add(1'b0, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 0, 0);
        add(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 0, 0);
        add(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 0, 0);
        add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 0, 0);
        // Lock again on ch0 (round-robin would now favour ch1)
        add(1'b0, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 1, 0);
        add(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 1, 0);
        add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1, 0);
        // Lock on ch1 (fixed priority would otherwise pick ch0)
        add(1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 2, 1);
        add(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 2, 1);
        add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, 2, 1);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hB0, 1'b0, 2'b00, 2'b01, 3, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hB1, 1'b0, 2'b00, 2'b01, 2, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hB2, 1'b0, 2'b00, 2'b10, 1, 0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // T5: fill to full, pop while full, resume next cycle
        for (int k = 0; k < 4; k++)
            add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, k, 0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 4, 0);
        add(1'b0, 2'b01, 1'b1, 1'b1, 32'hC0, 1'b0, 2'b00, 2'b01, 4, 0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 3, 0);
        for (int k = 0; k < 4; k++)
            add(1'b0, 2'b00, 1'b0, 1'b1, 32'hD0 + k, 1'b0, 2'b00, 2'b01, 4 - k, 0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // T6: ch1 then ch0, responses in order, then stray response
        add(1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, 0, 1);
        add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hE0, 1'b0, 2'b00, 2'b10, 2, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hE1, 1'b0, 2'b00, 2'b01, 1, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hE2, 1'b0, 2'b00, 2'b00, 0, 0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 0, 0);
        // Reset mid-operation discards IDs; later response is a stray
        add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 0, 0);
        add(1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, 1, 1);
        add(1'b1, 2'b00, 1'b0, 1'b1, 32'hF0, 1'b0, 2'b00, 2'b00, 2, 0);
        add(1'b0, 2'b00, 1'b0, 1'b1, 32'hF1, 1'b0, 2'b00, 2'b00, 0, 0);

        // Fixed request fields for the table phase
        reset       = 1'b1;
        ch_req      = '0;
        ch_wr       = 2'b10;
        ch_size     = 4'b1010;
        ch_addr     = {tbl_addr[1], tbl_addr[0]};
        ch_wstrb    = 8'hF3;
        ch_wdata    = 64'h1111_2222_3333_4444;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset       = tbl[i].rst;
            ch_req      = tbl[i].req;
            mem_addr_ok = tbl[i].aok;
            mem_data_ok = tbl[i].dok;
            mem_rdata   = tbl[i].rdata;
            #1;
            cmp($sformatf("t%0d.mem_req", i), 64'(mem_req), 64'(tbl[i].emreq));
            cmp($sformatf("t%0d.ch_addr_ok", i), 64'(ch_addr_ok), 64'(tbl[i].eaok));
            cmp($sformatf("t%0d.ch_data_ok", i), 64'(ch_data_ok), 64'(tbl[i].edok));
            cmp($sformatf("t%0d.outstanding", i), 64'(outstanding), 64'(tbl[i].eout));
            if (tbl[i].emreq) cmp($sformatf("t%0d.mem_addr", i), 64'(mem_addr), 64'(tbl_addr[tbl[i].ech]));
            if (tbl[i].edok != 2'b00) cmp($sformatf("t%0d.ch_rdata", i), 64'(ch_rdata), 64'(tbl[i].rdata));
            close_vec();
        end

        // ---------------- randomized phase ----------------
        lock_ch = -1;
        rr      = 0;
        for (int c2 = 0; c2 < N; c2++) pend[c2] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int c2 = 0; c2 < N; c2++) begin
                if (!pend[c2] && $urandom_range(0, 2) == 0) begin
                    pend[c2]  = 1'b1;
                    raddr[c2] = $urandom;
                    rwr[c2]   = 1'($urandom_range(0, 1));
                    rsize[c2] = 2'($urandom_range(0, 2));
                    rstrb[c2] = 4'($urandom_range(0, 15));
                    rwdat[c2] = $urandom;
                end
                ch_req[c2]             = pend[c2];
                ch_wr[c2]              = rwr[c2];
                ch_size[c2*2 +: 2]     = rsize[c2];
                ch_addr[c2*AW +: AW]   = raddr[c2];
                ch_wstrb[c2*SW +: SW]  = rstrb[c2];
                ch_wdata[c2*DW +: DW]  = rwdat[c2];
            end
            reset       = (cyc < 2) || ($urandom_range(0, 299) == 0);
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            #1;
            // Expected behaviour from the rules: a stalled grant is held; otherwise
            // search from the fairness start point (0 for fixed priority).
            full = (q.size() == MAXO);
            any  = 1'b0;
            g    = 0;
            if (lock_ch >= 0) begin
                any = 1'b1;
                g   = lock_ch;
            end else begin
                start = RR_MODE ? rr : 0;
                for (int k = 0; k < N; k++) begin
                    c = (start + k) % N;
                    if (!any && pend[c]) begin
                        any = 1'b1;
                        g   = c;
                    end
                end
            end
            mreq = any && !full && !reset;
            hs   = mreq && mem_addr_ok;
            pop  = mem_data_ok && (q.size() > 0) && !reset;
            cmp($sformatf("r%0d.mem_req", cyc), 64'(mem_req), 64'(mreq));
            cmp($sformatf("r%0d.ch_addr_ok", cyc), 64'(ch_addr_ok), hs ? (64'd1 << g) : 64'd0);
            cmp($sformatf("r%0d.ch_data_ok", cyc), 64'(ch_data_ok), pop ? (64'd1 << q[0]) : 64'd0);
            cmp($sformatf("r%0d.outstanding", cyc), 64'(outstanding), 64'(q.size()));
            if (mreq) begin
                cmp($sformatf("r%0d.mem_addr", cyc), 64'(mem_addr), 64'(raddr[g]));
                cmp($sformatf("r%0d.mem_wr", cyc), 64'(mem_wr), 64'(rwr[g]));
                cmp($sformatf("r%0d.mem_size", cyc), 64'(mem_size), 64'(rsize[g]));
                cmp($sformatf("r%0d.mem_wstrb", cyc), 64'(mem_wstrb), 64'(rstrb[g]));
                cmp($sformatf("r%0d.mem_wdata", cyc), 64'(mem_wdata), 64'(rwdat[g]));
            end
            if (pop) cmp($sformatf("r%0d.ch_rdata", cyc), 64'(ch_rdata), 64'(mem_rdata));
            close_vec();
            @(posedge clk);
            if (reset) begin
                q.delete();
                lock_ch = -1;
                rr      = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (hs) begin
                    q.push_back(g);
                    rr      = (g + 1) % N;
                    lock_ch = -1;
                    pend[g] = 1'b0;
                end else if (mreq) begin
                    lock_ch = g;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
